// File: rtl/median_pkg.sv
// Shared constants and FSM encoding for the nine-frame temporal median filter
// (buffer bank and median9_reduce).
package median_pkg;

  localparam int MED_TAPS     = 9;
  localparam int MED_CORE_LAT = 3;

  localparam int MED_DATA_W   = 64;
  localparam int MED_ADDR_W   = 10;
  localparam int MED_N_BINS   = 1024;
  localparam int MED_RD_LAT   = 2;

  localparam logic [3:0] MED_FRAMES_FULL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } med_state_e;

endpackage

// File: rtl/median9_core.sv
// Three-stage pipelined 9-way median (sort triples, reduce lo/mid/hi, final median)
// with the valid/address sideband carried alongside. All compares are unsigned.
module median9_core
  import median_pkg::*;
#(
  parameter int DATA_W = MED_DATA_W,
  parameter int ADDR_W = MED_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data [MED_TAPS],
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              inflight
);

  typedef logic [DATA_W-1:0] word_t;

  function automatic word_t f_min(input word_t a, input word_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic word_t f_max(input word_t a, input word_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic word_t f_med3(input word_t a, input word_t b, input word_t c);
    return f_max(f_min(a, b), f_min(f_max(a, b), c));
  endfunction

  word_t             r_lo_p0  [3];
  word_t             r_mid_p0 [3];
  word_t             r_hi_p0  [3];
  logic [ADDR_W-1:0] r_addr_p0;
  logic              r_vld_p0;

  word_t             r_a_p1;
  word_t             r_b_p1;
  word_t             r_c_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic              r_vld_p1;

  word_t             r_data_p2;
  logic [ADDR_W-1:0] r_addr_p2;
  logic              r_vld_p2;

  // Stage 1: sort each triple into lo/mid/hi
  always_ff @(posedge clk) begin
    for (int t = 0; t < 3; t++) begin
      r_lo_p0[t]  <= f_min(f_min(in_data[3*t], in_data[3*t+1]), in_data[3*t+2]);
      r_mid_p0[t] <= f_med3(in_data[3*t], in_data[3*t+1], in_data[3*t+2]);
      r_hi_p0[t]  <= f_max(f_max(in_data[3*t], in_data[3*t+1]), in_data[3*t+2]);
    end
    r_addr_p0 <= in_addr;
  end

  // Stage 2: max of lows, median of mids, min of highs
  always_ff @(posedge clk) begin
    r_a_p1    <= f_max(f_max(r_lo_p0[0], r_lo_p0[1]), r_lo_p0[2]);
    r_b_p1    <= f_med3(r_mid_p0[0], r_mid_p0[1], r_mid_p0[2]);
    r_c_p1    <= f_min(f_min(r_hi_p0[0], r_hi_p0[1]), r_hi_p0[2]);
    r_addr_p1 <= r_addr_p0;
  end

  // Stage 3: final median; output regs hold their last result between valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p2 <= '0;
      r_addr_p2 <= '0;
    end else if (r_vld_p1) begin
      r_data_p2 <= f_med3(r_a_p1, r_b_p1, r_c_p1);
      r_addr_p2 <= r_addr_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= in_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_addr  = r_addr_p2;
  assign inflight  = r_vld_p0 | r_vld_p1;

endmodule

// File: rtl/median9_reduce.sv
// Sweeps all bins of the nine frame RAMs after each full frame and streams the
// per-bin 9-way median. Define MEDIAN_OVERRUN_CNT_EN to add the overrun_cnt port.
module median9_reduce
  import median_pkg::*;
#(
  parameter int DATA_W = MED_DATA_W,
  parameter int ADDR_W = MED_ADDR_W,
  parameter int N_BINS = MED_N_BINS,
  parameter int RD_LAT = MED_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  input  logic [DATA_W-1:0] rd_data_3,
  input  logic [DATA_W-1:0] rd_data_4,
  input  logic [DATA_W-1:0] rd_data_5,
  input  logic [DATA_W-1:0] rd_data_6,
  input  logic [DATA_W-1:0] rd_data_7,
  input  logic [DATA_W-1:0] rd_data_8,
  input  logic [DATA_W-1:0] rd_data_9,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
`ifdef MEDIAN_OVERRUN_CNT_EN
  ,
  output logic [15:0]       overrun_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);

  med_state_e        r_state;
  med_state_e        w_state_nxt;
  logic [3:0]        r_frame_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [RD_LAT-1:0] r_vld_sr;
  logic [ADDR_W-1:0] r_addr_sr [RD_LAT];

  logic              w_start;
  logic              w_issue;
  logic              w_core_inflight;
  logic [DATA_W-1:0] w_rd_data [MED_TAPS];

  // The counter value before this pulse's increment gates the start, so the
  // ninth frame_done after reset launches the first sweep.
  assign w_start = frame_done && (r_state == ST_IDLE) && (r_frame_cnt >= 4'd8);
  assign w_issue = (r_state == ST_SWEEP);
  assign busy    = (r_state != ST_IDLE);
  assign rd_addr = r_rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_rd_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(|r_vld_sr) && !w_core_inflight) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
    end else if (w_start) begin
      r_rd_addr <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (frame_done && (r_frame_cnt != MED_FRAMES_FULL)) begin
      r_frame_cnt <= r_frame_cnt + 4'd1;
    end
  end

`ifdef MEDIAN_OVERRUN_CNT_EN
  logic [15:0] r_overrun_cnt;

  // A frame_done that lands mid-sweep with a full bank is a dropped filter run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun_cnt <= '0;
    end else if (frame_done && busy && (r_frame_cnt == MED_FRAMES_FULL) &&
                 (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  // Read-latency alignment: issue valid and address follow the RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_addr_sr[0] <= r_rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      r_addr_sr[i] <= r_addr_sr[i-1];
    end
  end

  assign w_rd_data[0] = rd_data_1;
  assign w_rd_data[1] = rd_data_2;
  assign w_rd_data[2] = rd_data_3;
  assign w_rd_data[3] = rd_data_4;
  assign w_rd_data[4] = rd_data_5;
  assign w_rd_data[5] = rd_data_6;
  assign w_rd_data[6] = rd_data_7;
  assign w_rd_data[7] = rd_data_8;
  assign w_rd_data[8] = rd_data_9;

  median9_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (r_vld_sr[RD_LAT-1]),
    .in_addr   (r_addr_sr[RD_LAT-1]),
    .in_data   (w_rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .inflight  (w_core_inflight)
  );

  assign out_last = out_valid && (out_addr == LAST_ADDR);

endmodule

// File: tb/tb_median9_reduce.sv
// Bench for median9_reduce: modelled frame RAMs with 2-cycle read latency and a
// sort-based reference median per bin.
module tb_median9_reduce;

  localparam int DW   = 64;
  localparam int AW   = 10;
  localparam int NB   = 1024;
  localparam int CAPN = 1040;
  localparam logic [DW-1:0] P6 [9] = '{64'd6, 64'd900, 64'd3, 64'd7, 64'd1,
                                       64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd8, 64'd4};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_done = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
`ifdef MEDIAN_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  logic [DW-1:0] mem [9][NB];
  logic [AW-1:0] ram_a1 = '0;
  logic [AW-1:0] ram_a2 = '0;

  int n_vec = 0;
  int n_bad = 0;

  bit            cap_vld  [CAPN];
  bit            cap_last [CAPN];
  bit            cap_busy [CAPN];
  logic [AW-1:0] cap_addr [CAPN];
  logic [AW-1:0] cap_rda  [CAPN];
  logic [DW-1:0] cap_data [CAPN];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_a1 <= rd_addr;
    ram_a2 <= ram_a1;
  end

  median9_reduce dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .rd_addr    (rd_addr),
    .rd_data_1  (mem[0][ram_a2]),
    .rd_data_2  (mem[1][ram_a2]),
    .rd_data_3  (mem[2][ram_a2]),
    .rd_data_4  (mem[3][ram_a2]),
    .rd_data_5  (mem[4][ram_a2]),
    .rd_data_6  (mem[5][ram_a2]),
    .rd_data_7  (mem[6][ram_a2]),
    .rd_data_8  (mem[7][ram_a2]),
    .rd_data_9  (mem[8][ram_a2]),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy)
`ifdef MEDIAN_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  // Reference: sort the nine words of a bin and take the fifth.
  function automatic logic [DW-1:0] ref_median(input int a);
    logic [DW-1:0] v [9];
    logic [DW-1:0] t;
    for (int i = 0; i < 9; i++) v[i] = mem[i][a];
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[j-1] > v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      end
    end
    return v[4];
  endfunction

  // Pulses frame_done in cycle 0 (and optionally in cycle fd2), records outputs.
  task automatic capture(input int fd2);
    for (int c = 0; c < CAPN; c++) begin
      @(posedge clk); #1;
      frame_done = (c == 0) || (c == fd2);
      @(negedge clk);
      cap_vld[c]  = out_valid;
      cap_last[c] = out_last;
      cap_busy[c] = busy;
      cap_addr[c] = out_addr;
      cap_rda[c]  = rd_addr;
      cap_data[c] = out_data;
    end
    @(posedge clk); #1;
    frame_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rd_addr !== '0) begin n_bad++; $display("FAIL reset_rd_addr: got %0h want 0", rd_addr); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_vec++; if (out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr: got %0h want 0", out_addr); end
    n_vec++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
`ifdef MEDIAN_OVERRUN_CNT_EN
    n_vec++; if (overrun_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_prefill();
    int seen_busy, seen_vld;
    seen_busy = 0; seen_vld = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 frame_done = 1'b1;
      @(negedge clk);
      if (busy) seen_busy++;
      if (out_valid) seen_vld++;
      @(posedge clk); #1 frame_done = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (busy) seen_busy++;
        if (out_valid) seen_vld++;
      end
    end
    n_vec++; if (seen_busy !== 0) begin n_bad++; $display("FAIL prefill_busy: got %0d busy cycles want 0", seen_busy); end
    n_vec++; if (seen_vld !== 0) begin n_bad++; $display("FAIL prefill_valid: got %0d valid cycles want 0", seen_vld); end
  endtask

  task automatic test_const_sweep();
    int first, nv, nl, nb;
    for (int i = 0; i < 9; i++)
      for (int a = 0; a < NB; a++) mem[i][a] = DW'(i + 1);
    capture(-1);
    first = -1; nv = 0; nl = 0; nb = 0;
    for (int c = 0; c < CAPN; c++) begin
      if (cap_busy[c]) nb++;
      if (cap_last[c]) nl++;
      if (cap_vld[c]) begin
        if (first < 0) first = c;
        nv++;
        n_vec++;
        if (cap_data[c] !== 64'd5 || cap_addr[c] !== AW'(c - 6)) begin
          n_bad++;
          $display("FAIL const_bin: cycle %0d got addr %0d data %0h want addr %0d data 5",
                   c, cap_addr[c], cap_data[c], c - 6);
        end
      end
    end
    n_vec++; if (cap_busy[0] !== 1'b0) begin n_bad++; $display("FAIL const_busy_pre: got 1 want 0"); end
    n_vec++; if (cap_rda[1] !== '0) begin n_bad++; $display("FAIL const_rd_addr0: got %0d want 0", cap_rda[1]); end
    n_vec++; if (first !== 6) begin n_bad++; $display("FAIL const_latency: first valid cycle %0d want 6", first); end
    n_vec++; if (nv !== NB) begin n_bad++; $display("FAIL const_count: got %0d want %0d", nv, NB); end
    n_vec++; if (nl !== 1) begin n_bad++; $display("FAIL const_last_count: got %0d want 1", nl); end
    n_vec++; if (cap_last[1029] !== 1'b1 || cap_addr[1029] !== AW'(NB - 1)) begin
      n_bad++; $display("FAIL const_last_pos: got last %0b addr %0d want 1 addr %0d", cap_last[1029], cap_addr[1029], NB - 1);
    end
    n_vec++; if (nb !== NB + 5) begin n_bad++; $display("FAIL const_busy_len: got %0d want %0d", nb, NB + 5); end
    n_vec++; if (cap_busy[1029] !== 1'b1 || cap_busy[1030] !== 1'b0) begin
      n_bad++; $display("FAIL const_busy_fall: got %0b%0b want 10", cap_busy[1029], cap_busy[1030]);
    end
  endtask

  task automatic test_random_sweep();
    int nv;
    logic [AW-1:0] expa;
    logic [DW-1:0] expd;
    for (int a = 0; a < NB; a++)
      for (int i = 0; i < 9; i++)
        case (a % 3)
          0:       mem[i][a] = {$urandom, $urandom};
          1:       mem[i][a] = DW'($urandom_range(0, 3));
          default: mem[i][a] = {1'b1, 31'($urandom), $urandom};
        endcase
    for (int i = 0; i < 9; i++) begin
      mem[i][6] = (i == 0) ? 64'd6 : P6[i];
      mem[i][7] = (i == 8) ? 64'd0 : 64'h1234;
    end
    capture(-1);
    nv = 0; expa = '0;
    for (int c = 0; c < CAPN; c++) begin
      if (cap_vld[c]) begin
        expd = ref_median(int'(expa));
        n_vec++;
        if (cap_data[c] !== expd || cap_addr[c] !== expa) begin
          n_bad++;
          $display("FAIL rand_bin: cycle %0d got addr %0d data %0h want addr %0d data %0h",
                   c, cap_addr[c], cap_data[c], expa, expd);
        end
        expa = expa + 1'b1;
        nv++;
      end
    end
    n_vec++; if (nv !== NB) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", nv, NB); end
    n_vec++; if (cap_vld[12] !== 1'b1 || cap_data[12] !== 64'd6) begin
      n_bad++; $display("FAIL top_value_bin6: got vld %0b data %0h want 1 data 6", cap_vld[12], cap_data[12]);
    end
    n_vec++; if (cap_vld[13] !== 1'b1 || cap_data[13] !== 64'h1234) begin
      n_bad++; $display("FAIL dup_bin7: got vld %0b data %0h want 1 data 1234", cap_vld[13], cap_data[13]);
    end
  endtask

  task automatic test_overrun();
    int nv, nl;
    logic [AW-1:0] expa;
    logic [DW-1:0] expd;
    capture(301);
    nv = 0; nl = 0; expa = '0;
    for (int c = 0; c < CAPN; c++) begin
      if (cap_last[c]) nl++;
      if (cap_vld[c]) begin
        expd = ref_median(int'(expa));
        n_vec++;
        if (cap_data[c] !== expd || cap_addr[c] !== expa) begin
          n_bad++;
          $display("FAIL overrun_bin: cycle %0d got addr %0d data %0h want addr %0d data %0h",
                   c, cap_addr[c], cap_data[c], expa, expd);
        end
        expa = expa + 1'b1;
        nv++;
      end
    end
    n_vec++; if (cap_rda[301] !== AW'(300)) begin n_bad++; $display("FAIL overrun_pulse_bin: got %0d want 300", cap_rda[301]); end
    n_vec++; if (nv !== NB) begin n_bad++; $display("FAIL overrun_count: got %0d want %0d", nv, NB); end
    n_vec++; if (nl !== 1) begin n_bad++; $display("FAIL overrun_last_count: got %0d want 1", nl); end
    n_vec++; if (cap_busy[1030] !== 1'b0) begin n_bad++; $display("FAIL overrun_busy_fall: got 1 want 0"); end
`ifdef MEDIAN_OVERRUN_CNT_EN
    n_vec++; if (overrun_cnt !== 16'd1) begin n_bad++; $display("FAIL overrun_cnt: got %0d want 1", overrun_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int seen, first, nv, nl;
    @(posedge clk); #1 frame_done = 1'b1;
    @(posedge clk); #1 frame_done = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    n_vec++; if (rd_addr !== AW'(500) || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got rd_addr %0d valid %0b want 500 1", rd_addr, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %0b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
    n_vec++; if (rd_addr !== '0) begin n_bad++; $display("FAIL mid_rd_addr: got %0d want 0", rd_addr); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || out_last || busy) seen++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef MEDIAN_OVERRUN_CNT_EN
    n_vec++; if (overrun_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_overrun: got %0d want 0", overrun_cnt); end
`endif
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 frame_done = 1'b1;
      @(negedge clk);
      if (out_valid || out_last || busy) seen++;
      @(posedge clk); #1 frame_done = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (out_valid || out_last || busy) seen++;
      end
    end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL mid_quiet: got %0d active cycles want 0", seen); end
    capture(-1);
    first = -1; nv = 0; nl = 0;
    for (int c = 0; c < CAPN; c++) begin
      if (cap_vld[c]) begin
        if (first < 0) first = c;
        nv++;
      end
      if (cap_last[c]) nl++;
    end
    n_vec++; if (first !== 6) begin n_bad++; $display("FAIL mid_resweep_latency: got %0d want 6", first); end
    n_vec++; if (nv !== NB) begin n_bad++; $display("FAIL mid_resweep_count: got %0d want %0d", nv, NB); end
    n_vec++; if (nl !== 1 || cap_last[1029] !== 1'b1) begin
      n_bad++; $display("FAIL mid_resweep_last: got count %0d at1029 %0b want 1 1", nl, cap_last[1029]);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_const_sweep();
    test_random_sweep();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
